// File: rtl/f_fetch_unit.sv
// Instruction fetch stage: drives a single-outstanding-request instruction
// memory, buffers a word returned during a stall, and loads the F/D pipeline
// register with either a real instruction or a bubble on every unstalled edge.
module f_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_npc,
  input  logic        in_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_Fpc,
  output logic [31:0] out_Dinstr,
  output logic [31:0] out_Dpc,
  output logic        out_Dvalid,
  output logic        out_Dadel,
  output logic        out_busy
);

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_LO    = 32'h0000_3000;
  localparam logic [31:0] PC_HI    = 32'h0000_6FFC;

  typedef enum logic [1:0] {FETCH, WAIT, READY} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic [31:0] dinstr_q;
  logic [31:0] dpc_q;
  logic        dvalid_q;
  logic        dadel_q;

  logic        addr_err;
  logic        ack;
  logic        word_ready;
  logic        advance;
  logic [31:0] fetch_word;

  // Misaligned or out-of-window PCs never reach memory; they behave as an
  // already-fetched all-zero word tagged with an address error.
  always_comb begin
    addr_err   = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);
    imem_req   = !reset && !addr_err && (state_q != READY);
    ack        = imem_req && imem_ack;
    word_ready = ack || addr_err || (state_q == READY);
    advance    = word_ready && !in_stall;
    out_busy   = imem_req && !imem_ack;
    if (addr_err)
      fetch_word = 32'h0000_0000;
    else if (ack)
      fetch_word = imem_rdata;
    else
      fetch_word = buf_q;
  end

  // Fetch FSM, PC, stall buffer and F/D register; reset overrides stall and ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= PC_RESET;
      buf_q    <= 32'h0000_0000;
      dinstr_q <= 32'h0000_0000;
      dpc_q    <= PC_RESET;
      dvalid_q <= 1'b0;
      dadel_q  <= 1'b0;
    end else if (advance) begin
      dinstr_q <= fetch_word;
      dpc_q    <= pc_q;
      dvalid_q <= 1'b1;
      dadel_q  <= addr_err;
      pc_q     <= in_npc;
      state_q  <= FETCH;
    end else begin
      if (!in_stall) begin
        // Nothing to hand over this edge: the decode stage sees a bubble.
        dinstr_q <= 32'h0000_0000;
        dpc_q    <= pc_q;
        dvalid_q <= 1'b0;
        dadel_q  <= 1'b0;
      end
      if (ack) begin
        // Only reachable while stalled: park the word until decode can take it.
        buf_q   <= imem_rdata;
        state_q <= READY;
      end else if (imem_req) begin
        state_q <= WAIT;
      end
    end
  end

  assign imem_addr  = pc_q;
  assign out_Fpc    = pc_q;
  assign out_Dinstr = dinstr_q;
  assign out_Dpc    = dpc_q;
  assign out_Dvalid = dvalid_q;
  assign out_Dadel  = dadel_q;

endmodule
